// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite register responder: ID, scratch, down-count timer with IRQ, GPIO.
// Define AXI_LITE_REG_RESPONDER_WSTRB_EN to honour per-byte write strobes.
module axi_lite_reg_responder #(
  parameter logic [31:0] ID_VALUE    = 32'h56455230,
  parameter int          GPIO_WIDTH  = 16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic [31:0]           s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [31:0]           s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic                  irq
);

  localparam logic [2:0] A_ID      = 3'd0;
  localparam logic [2:0] A_SCRATCH = 3'd1;
  localparam logic [2:0] A_CTRL    = 3'd2;
  localparam logic [2:0] A_STATUS  = 3'd3;
  localparam logic [2:0] A_LOAD    = 3'd4;
  localparam logic [2:0] A_COUNT   = 3'd5;
  localparam logic [2:0] A_GPOUT   = 3'd6;

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [31:0] m
  );
    return (old_v & ~m) | (new_v & m);
  endfunction

  logic                  up;
  logic                  aw_held;
  logic                  w_held;
  logic                  commit;
  logic [2:0]            aw_idx;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic [31:0]           wm;
  logic [31:0]           scratch;
  logic [31:0]           load;
  logic [31:0]           count;
  logic [1:0]            ctrl;
  logic [1:0]            ctrl_new;
  logic                  expired;
  logic                  ro_hit;
  logic                  timer_rise;
  logic                  hw_set;
  logic                  w1c;
  logic                  wr_scratch;
  logic                  wr_ctrl;
  logic                  wr_status;
  logic                  wr_load;
  logic                  wr_gpio;
  logic [GPIO_WIDTH-1:0] gpio_q;
  logic [GPIO_WIDTH-1:0] gpio_in;
  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [31:0]           rd_mux;
  logic                  unused;

`ifdef AXI_LITE_REG_RESPONDER_WSTRB_EN
  assign wm = {{8{w_strb[3]}}, {8{w_strb[2]}},
               {8{w_strb[1]}}, {8{w_strb[0]}}};
  assign unused = ^{s_axi_awaddr[31:5], s_axi_awaddr[1:0],
                    s_axi_araddr[31:5], s_axi_araddr[1:0],
                    s_axi_awprot, s_axi_arprot};
`else
  assign wm = '1;
  assign unused = ^{s_axi_awaddr[31:5], s_axi_awaddr[1:0],
                    s_axi_araddr[31:5], s_axi_araddr[1:0],
                    s_axi_awprot, s_axi_arprot, w_strb};
`endif

  // Ready lines stay low until the first edge after reset release.
  assign s_axi_awready = up & ~aw_held & ~s_axi_bvalid;
  assign s_axi_wready  = up & ~w_held & ~s_axi_bvalid;
  assign s_axi_arready = up & ~s_axi_rvalid;
  assign s_axi_rresp   = 2'b00;
  assign commit        = aw_held & w_held & ~s_axi_bvalid;
  assign gpio_o        = gpio_q;
  assign gpio_in       = sync_q[SYNC_STAGES-1];

  always_comb begin
    wr_scratch = 1'b0;
    wr_ctrl    = 1'b0;
    wr_status  = 1'b0;
    wr_load    = 1'b0;
    wr_gpio    = 1'b0;
    ro_hit     = 1'b0;
    unique case (1'b1)
      aw_idx == A_SCRATCH: wr_scratch = commit;
      aw_idx == A_CTRL:    wr_ctrl    = commit;
      aw_idx == A_STATUS:  wr_status  = commit;
      aw_idx == A_LOAD:    wr_load    = commit;
      aw_idx == A_GPOUT:   wr_gpio    = commit;
      default:             ro_hit     = 1'b1;
    endcase
  end

  assign ctrl_new   = wr_ctrl ? 2'(merge({30'd0, ctrl}, w_data, wm))
                              : ctrl;
  assign timer_rise = ctrl_new[0] & ~ctrl[0];
  assign hw_set     = ctrl[0] & (count == '0);
  assign w1c        = wr_status & w_data[0] & wm[0];

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      up           <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else begin
      up <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi_awaddr[4:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= ro_hit ? 2'b10 : 2'b00;
      end
      if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      scratch <= '0;
      load    <= '0;
      ctrl    <= '0;
      gpio_q  <= '0;
    end else begin
      if (wr_scratch) scratch <= merge(scratch, w_data, wm);
      if (wr_load)    load    <= merge(load, w_data, wm);
      if (wr_gpio)    gpio_q  <= GPIO_WIDTH'(merge(32'(gpio_q), w_data, wm));
      ctrl <= ctrl_new;
    end
  end

  // A hardware expiry overrides a same-cycle W1C so no event is lost.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      count   <= '0;
      expired <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (timer_rise) begin
        count <= load;
      end else if (ctrl[0]) begin
        count <= (count == '0) ? load : count - 32'd1;
      end
      expired <= (expired & ~w1c) | hw_set;
      irq     <= expired & ctrl[1];
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[4:2])
      A_ID:      rd_mux = ID_VALUE;
      A_SCRATCH: rd_mux = scratch;
      A_CTRL:    rd_mux = {30'd0, ctrl};
      A_STATUS:  rd_mux = {31'd0, expired};
      A_LOAD:    rd_mux = load;
      A_COUNT:   rd_mux = count;
      A_GPOUT:   rd_mux = 32'(gpio_q);
      default:   rd_mux = 32'(gpio_in);
    endcase
  end

  // Capturing at the AR handshake returns pre-write data on a same-cycle commit.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_mux;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Scoreboard bench for axi_lite_reg_responder with a cycle-level register model.
// Random AXI-Lite traffic; B/R responses checked by a separate monitor.
module tb_axi_lite_reg_responder;

  localparam int          GW  = 16;
  localparam int          SS  = 2;
  localparam logic [31:0] IDV = 32'h56455230;

  logic          aclk = 1'b0;
  logic          arstn = 1'b0;
  logic [31:0]   awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [31:0]   araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [GW-1:0] gpio_o;
  logic [GW-1:0] gpio_i = '0;
  logic          irq;

  always #5 aclk = ~aclk;

  axi_lite_reg_responder #(
    .ID_VALUE(IDV), .GPIO_WIDTH(GW), .SYNC_STAGES(SS)
  ) dut (
    .aclk(aclk), .arstn(arstn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .gpio_o(gpio_o), .gpio_i(gpio_i), .irq(irq)
  );

  int vectors = 0;
  int miscompares = 0;
  bit abort = 1'b0;
  logic [31:0] rq[$];
  logic [1:0]  bq[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Reference register state, advanced once per clock edge.
  logic [31:0] m_scratch, m_load, m_count;
  logic [1:0]  m_ctrl;
  logic        m_exp, m_irq;
  logic [GW-1:0] m_gpio;
  logic [GW-1:0] hist [SS];
  logic        cm_valid = 1'b0;
  logic [31:0] cm_addr = '0, cm_data = '0;
  logic [3:0]  cm_strb = '0;

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++)
`ifdef AXI_LITE_REG_RESPONDER_WSTRB_EN
      m[i*8 +: 8] = {8{s[i]}};
`else
      m[i*8 +: 8] = {8{s[i] | 1'b1}};
`endif
    return m;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[4:2])
      3'd0: return IDV;
      3'd1: return m_scratch;
      3'd2: return {30'd0, m_ctrl};
      3'd3: return {31'd0, m_exp};
      3'd4: return m_load;
      3'd5: return m_count;
      3'd6: return 32'(m_gpio);
      default: return 32'(hist[SS-1]);
    endcase
  endfunction

  always @(posedge aclk or negedge arstn) begin : model
    logic [31:0] mk, tmp, old_load, old_count;
    logic old_en, old_ien, old_exp, clr, set;
    if (!arstn) begin
      m_scratch = '0; m_load = '0; m_count = '0; m_ctrl = '0;
      m_exp = 1'b0; m_irq = 1'b0; m_gpio = '0;
      for (int i = 0; i < SS; i++) hist[i] = '0;
    end else begin
      old_en = m_ctrl[0]; old_ien = m_ctrl[1];
      old_load = m_load; old_count = m_count; old_exp = m_exp;
      clr = 1'b0; set = 1'b0;
      if (cm_valid) begin
        mk = lane_mask(cm_strb);
        case (cm_addr[4:2])
          3'd1: m_scratch = (m_scratch & ~mk) | (cm_data & mk);
          3'd2: begin
            tmp = ({30'd0, m_ctrl} & ~mk) | (cm_data & mk);
            m_ctrl = tmp[1:0];
          end
          3'd3: clr = cm_data[0] & mk[0];
          3'd4: m_load = (m_load & ~mk) | (cm_data & mk);
          3'd6: begin
            tmp = (32'(m_gpio) & ~mk) | (cm_data & mk);
            m_gpio = tmp[GW-1:0];
          end
          default: ;
        endcase
        cm_valid = 1'b0;
      end
      if (!old_en && m_ctrl[0]) m_count = old_load;
      else if (old_en) begin
        if (old_count == 0) begin m_count = old_load; set = 1'b1; end
        else m_count = old_count - 1;
      end
      m_exp = (old_exp & ~clr) | set;
      m_irq = old_exp & old_ien;
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = gpio_i;
    end
  end

  always @(negedge aclk) begin : monitor
    logic [31:0] want;
    if (arstn) begin
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          miscompares++;
          $display("FAIL r_unexpected: got rdata %h, want no response", rdata);
        end else begin
          want = rq.pop_front();
          check("rdata", rdata, want);
          check("rresp", 32'(rresp), 32'd0);
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          miscompares++;
          $display("FAIL b_unexpected: got bresp %h, want no response", bresp);
        end else check("bresp", 32'(bresp), 32'(bq.pop_front()));
      end
      check("irq", 32'(irq), 32'(m_irq));
      check("gpio_o", 32'(gpio_o), 32'(m_gpio));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int lead,
                          input int bdel);
    int ta, tw, t;
    bit aw_done, w_done, hs_a, hs_w, hs;
    if (abort) return;
    ta = lead > 0 ? lead : 0;
    tw = lead < 0 ? -lead : 0;
    bq.push_back((a[4:2] == 3'd0 || a[4:2] == 3'd5 || a[4:2] == 3'd7)
                 ? 2'b10 : 2'b00);
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      if (!aw_done && t >= ta) begin
        awvalid = 1'b1; awaddr = a; awprot = 3'($urandom);
      end
      if (!w_done && t >= tw) begin
        wvalid = 1'b1; wdata = d; wstrb = s;
      end
      @(negedge aclk);
      hs_a = awvalid && awready;
      hs_w = wvalid && wready;
      @(posedge aclk); #1;
      if (hs_a) begin aw_done = 1; awvalid = 1'b0; end
      if (hs_w) begin w_done = 1; wvalid = 1'b0; end
      t++;
    end
    if (!(aw_done && w_done)) begin
      miscompares++;
      $display("FAIL aw_w_timeout: got aw=%0d w=%0d, want both", aw_done, w_done);
      awvalid = 1'b0; wvalid = 1'b0; void'(bq.pop_back()); abort = 1'b1;
      return;
    end
    cm_addr = a; cm_data = d; cm_strb = s; cm_valid = 1'b1;
    @(negedge aclk);
    check("bvalid_early", 32'(bvalid), 32'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("bvalid_rise", 32'(bvalid), 32'd1);
    for (int i = 0; i < bdel; i++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      check("bvalid_hold", 32'(bvalid), 32'd1);
    end
    @(posedge aclk); #1;
    bready = 1'b1;
    t = 0;
    do begin
      @(negedge aclk);
      hs = bvalid && bready;
      @(posedge aclk); #1;
      t++;
    end while (!hs && t < 50);
    bready = 1'b0;
    if (!hs) begin
      miscompares++;
      $display("FAIL b_timeout: got bvalid=%0d, want 1", bvalid);
      abort = 1'b1;
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int rdel);
    int t;
    bit hs;
    if (abort) return;
    arvalid = 1'b1; araddr = a; arprot = 3'($urandom);
    t = 0;
    do begin
      @(negedge aclk);
      hs = arvalid && arready;
      if (hs) rq.push_back(m_read(a));
      @(posedge aclk); #1;
      t++;
    end while (!hs && t < 50);
    arvalid = 1'b0;
    if (!hs) begin
      miscompares++;
      $display("FAIL ar_timeout: got arready=%0d, want 1", arready);
      abort = 1'b1;
      return;
    end
    @(negedge aclk);
    check("rvalid_latency", 32'(rvalid), 32'd1);
    for (int i = 0; i < rdel; i++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      check("rvalid_hold", 32'(rvalid), 32'd1);
    end
    @(posedge aclk); #1;
    rready = 1'b1;
    t = 0;
    do begin
      @(negedge aclk);
      hs = rvalid && rready;
      @(posedge aclk); #1;
      t++;
    end while (!hs && t < 50);
    rready = 1'b0;
    if (!hs) begin
      miscompares++;
      $display("FAIL r_timeout: got rvalid=%0d, want 1", rvalid);
      abort = 1'b1;
    end
  endtask

  initial begin
    repeat (50000) @(posedge aclk);
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge aclk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_gpio_o", 32'(gpio_o), 32'd0);
    @(posedge aclk); #1;
    arstn = 1'b1;
    idle(1);

    do_read(32'h0, 0);
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 3, 4);
    do_read(32'h4, 1);
    do_write(32'h14, 32'h1, 4'hF, 0, 0);
    do_read(32'h14, 0);
    do_write(32'h10, 32'd3, 4'hF, -1, 0);
    do_write(32'h8, 32'd3, 4'hF, 0, 0);
    idle(9);
    do_read(32'hC, 0);
    do_write(32'hC, 32'd1, 4'hF, 0, 0);
    idle(10);
    do_write(32'h8, 32'd0, 4'hF, 0, 0);
    do_write(32'h18, 32'h0000A5A5, 4'hF, 0, 0);
    gpio_i = 16'h1234;
    idle(SS + 1);
    do_read(32'h1C, 0);
    do_write(32'h4, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_write(32'h4, 32'h0, 4'b0010, 0, 0);
    do_read(32'h4, 0);
    do_write(32'h4, 32'h0, 4'b0000, 0, 0);
    do_read(32'h4, 0);
    fork
      do_write(32'h4, 32'h12345678, 4'hF, 0, 0);
      begin @(posedge aclk); #1; do_read(32'h4, 0); end
    join
    do_read(32'h4, 0);
    do_write(32'h10, 32'd0, 4'hF, 0, 0);
    do_write(32'h8, 32'd3, 4'hF, 0, 0);
    idle(4);
    do_write(32'hC, 32'd1, 4'hF, 0, 0);
    do_read(32'hC, 0);
    do_write(32'h8, 32'd0, 4'hF, 0, 0);

    for (int n = 0; n < 250 && !abort; n++) begin
      int op, idx;
      logic [31:0] a, d;
      logic [3:0] s;
      op  = $urandom_range(0, 9);
      idx = $urandom_range(0, 7);
      a   = ($urandom & 32'hFFFF_FFE3) | (32'(idx) << 2);
      d   = $urandom;
      if (idx == 4 && $urandom_range(0, 1) == 1) d = $urandom_range(0, 6);
      s   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      if (op < 4)
        do_write(a, d, s, int'($urandom_range(0, 6)) - 3,
                 $urandom_range(0, 3));
      else if (op < 8)
        do_read(a, $urandom_range(0, 3));
      else if (op == 8) begin
        gpio_i = GW'($urandom);
        idle(1);
      end else
        idle($urandom_range(1, 6));
    end

    idle(4);
    vectors++;
    if (rq.size() != 0 || bq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d R and %0d B outstanding, want 0",
               rq.size(), bq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_responder.md
Name: axi_lite_reg_responder

Overview:
- AXI4-Lite slave (responder) for the PS AXI-Lite master port, which is currently tied off at the system top.
- Provides a small register bank:
  - ID register
  - scratch register
  - programmable down-count timer with sticky status and level IRQ (feeds PS IRQ input)
  - GPIO output register
  - synchronised GPIO input register
- Single clock domain; the PS interconnect decodes the base address upstream.

Parameters:
ID_VALUE, 32'h56455230, constant returned by the ID register
GPIO_WIDTH, 16, width of gpio_o / gpio_i (1..32)
SYNC_STAGES, 2, flop stages on gpio_i (>=2)

Ports:
aclk  in  1  clock
arstn  in  1  async active-low reset
s_axi_awaddr  in  32  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  32  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read valid
s_axi_rready  in  1  read ready
gpio_o  out  GPIO_WIDTH  GPIO_OUT register value
gpio_i  in  GPIO_WIDTH  async input, synchronised internally
irq  out  1  registered level interrupt

Behaviour:
- Reset (arstn low, async): all ready/valid low, bresp=rresp=0, rdata=0, irq=0, gpio_o=0, all RW registers 0, sync chain 0. Deassertion takes effect at the next aclk edge.
- Register map (decode addr[4:2]; bits [1:0] and [31:5] ignored):
  - 0x00 ID: RO, ID_VALUE
  - 0x04 SCRATCH: RW
  - 0x08 CTRL: RW; bit0 timer_en, bit1 irq_en; others read 0
  - 0x0C STATUS: RW1C; bit0 expired
  - 0x10 LOAD: RW
  - 0x14 COUNT: RO
  - 0x18 GPIO_OUT: RW, low GPIO_WIDTH bits
  - 0x1C GPIO_IN: RO, synchronised gpio_i, zero-extended
- Write channel:
  - awready high while no AW is held and bvalid=0; wready high while no W is held and bvalid=0.
  - AW and W are accepted independently, in either order or in the same cycle.
  - The register update commits in the cycle both are held; bvalid rises the next cycle.
  - bvalid holds until bready; the held AW/W are cleared on that handshake.
  - Max one outstanding write.
  - bresp: OKAY (2'b00); SLVERR (2'b10) for writes to ID, COUNT, GPIO_IN (no state change).
- Read channel:
  - arready = !rvalid. rdata is captured at the AR handshake; rvalid is asserted the next cycle and holds until rready.
  - rresp is always OKAY.
  - If a write commits in the AR handshake cycle, the read returns the pre-write value.
- Timer:
  - CTRL.timer_en 0->1 loads COUNT=LOAD.
  - While enabled, COUNT decrements every cycle. At COUNT==0: COUNT reloads LOAD and STATUS.expired is set. With LOAD=0 the timer expires every cycle.
  - Disabling the timer freezes COUNT.
  - A hardware set of expired and a W1C in the same cycle: the set wins.
- irq: registered STATUS.expired & CTRL.irq_en; asserts 1 cycle after both are true.
- Reset mid-transaction: pending AW/W/B/R are discarded; the master must not expect a response.

Optional Feature:
- Macro: AXI_LITE_REG_RESPONDER_WSTRB_EN.
  - Defined: each byte lane of an RW register updates only where wstrb bit=1. In STATUS, W1C applies only within strobed lanes. wstrb=0 gives bresp OKAY with no change.
  - Undefined: wstrb is ignored and every accepted write updates the full word.

Test Plan:
- Read 0x00 after reset -> rdata=32'h56455230, rresp=00, rvalid 1 cycle after AR handshake.
- W before AW by 3 cycles, write 0x04=32'hDEADBEEF, bready held low 4 cycles -> bvalid held, bresp=00; readback 32'hDEADBEEF.
- Write 0x14 with 32'h1 -> bresp=10; COUNT unchanged.
- LOAD=3, CTRL=3 -> expired set 4 cycles after enable, irq 1 cycle later; write STATUS=1 -> irq clears, re-fires every 4 cycles.
- Write GPIO_OUT=16'hA5A5 -> gpio_o=A5A5; drive gpio_i=16'h1234 -> GPIO_IN read=0x00001234 after SYNC_STAGES+ cycles.
- With WSTRB_EN: SCRATCH=FFFFFFFF, write 0 with wstrb=4'b0010 -> readback FFFF00FF; without the macro -> 00000000.
